// File: rtl/sdram_port_arbiter.sv
// Four-port SDRAM arbiter: fixed-priority grant, one outstanding command,
// WAIT timeout abort and cassette starvation promotion.
module sdram_port_arbiter #(
   parameter int ADDR_W  = 23,
   parameter int TIMEOUT = 64,
   parameter int STARVE  = 256
) (
   input  logic                  clk_sys,
   input  logic                  reset_n,
   input  logic [3:0]            req_i,
   input  logic [3:0]            we_i,
   input  logic [4*ADDR_W-1:0]   addr_i,
   input  logic [31:0]           din_i,
   input  logic                  cas_window_i,
   output logic [3:0]            ack_o,
   output logic [7:0]            rdata_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   output logic [7:0]            mem_din_o,
   input  logic [7:0]            mem_dout_i,
   input  logic                  mem_ack_i,
   output logic                  busy_o,
   output logic [1:0]            grant_o,
   output logic                  timeout_o
);
   // state   | meaning
   // S_IDLE  | arbitrate; grantee fields latched on exit
   // S_ISSUE | mem_req_o strobe, timeout timer loaded
   // S_WAIT  | wait for mem_ack_i or timer terminal count
   // S_DONE  | ack_o[grant] (and timeout_o on abort)
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(STARVE + 1);

   logic [1:0]        state_q, state_d;
   logic [1:0]        grant_q, grant_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        din_q, din_d;
   logic [7:0]        rdata_q, rdata_d;
   logic              to_q, to_d;
   logic [TW-1:0]     tmr_q, tmr_d;
   logic [SW-1:0]     starve_q, starve_d;

   logic       starved;
   logic       cas_ok;
   logic       any_req;
   logic [1:0] sel_c;
   logic       cas_granted;

   assign starved = (starve_q >= SW'(STARVE));
   assign cas_ok  = req_i[3] & (cas_window_i | starved);
   assign any_req = req_i[0] | req_i[1] | req_i[2] | cas_ok;

   // A starved cassette outranks everything except the ioctl download.
   always_comb begin
      sel_c = 2'd3;
      if (req_i[0])                  sel_c = 2'd0;
      else if (req_i[3] && starved)  sel_c = 2'd3;
      else if (req_i[1])             sel_c = 2'd1;
      else if (req_i[2])             sel_c = 2'd2;
   end

   assign cas_granted = ((state_q == S_IDLE) && any_req && (sel_c == 2'd3)) ||
                        ((state_q != S_IDLE) && (grant_q == 2'd3));

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      we_d     = we_q;
      addr_d   = addr_q;
      din_d    = din_q;
      rdata_d  = rdata_q;
      to_d     = to_q;
      tmr_d    = tmr_q;
      starve_d = starve_q;

      if (!req_i[3] || cas_granted) starve_d = '0;
      else if (!starved)            starve_d = starve_q + SW'(1);

      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               state_d = S_ISSUE;
               grant_d = sel_c;
               we_d    = we_i[sel_c];
               addr_d  = addr_i[ADDR_W*int'(sel_c) +: ADDR_W];
               din_d   = din_i[8*int'(sel_c) +: 8];
               to_d    = 1'b0;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
            tmr_d   = TW'(TIMEOUT - 1);
         end
         S_WAIT: begin
            // A completion in the terminal cycle still counts as success.
            if (mem_ack_i) begin
               state_d = S_DONE;
               if (!we_q) rdata_d = mem_dout_i;
            end else if (tmr_q == '0) begin
               state_d = S_DONE;
               to_d    = 1'b1;
               if (!we_q) rdata_d = 8'hFF;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         grant_q  <= 2'd0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         din_q    <= 8'h00;
         rdata_q  <= 8'h00;
         to_q     <= 1'b0;
         tmr_q    <= '0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         rdata_q  <= rdata_d;
         to_q     <= to_d;
         tmr_q    <= tmr_d;
         starve_q <= starve_d;
      end
   end

   assign ack_o      = (state_q == S_DONE) ? (4'b0001 << grant_q) : 4'b0000;
   assign timeout_o  = (state_q == S_DONE) && to_q;
   assign mem_req_o  = (state_q == S_ISSUE);
   assign busy_o     = (state_q != S_IDLE);
   assign mem_we_o   = we_q;
   assign mem_addr_o = addr_q;
   assign mem_din_o  = din_q;
   assign rdata_o    = rdata_q;
   assign grant_o    = grant_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: vector table plus hand sequences, with a
// scoreboard of expected completions checked by a negedge monitor.
module tb_sdram_port_arbiter;
   localparam int AW = 23;

   logic clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   logic          reset_n;
   logic [3:0]    req, we;
   logic [4*AW-1:0] addr;
   logic [31:0]   din;
   logic          cas_win;
   logic [7:0]    mem_dout;
   logic          force_ack;

   logic [3:0]    ack   [2];
   logic [7:0]    rdata [2];
   logic          mreq  [2];
   logic          mwe   [2];
   logic [AW-1:0] maddr [2];
   logic [7:0]    mdin  [2];
   logic          mack  [2];
   logic          busy  [2];
   logic [1:0]    grant [2];
   logic          tmo   [2];

   // Instance 0: short starvation threshold; instance 1: default threshold.
   sdram_port_arbiter #(.ADDR_W(AW), .TIMEOUT(4), .STARVE(8)) u_a (
      .clk_sys(clk_sys), .reset_n(reset_n), .req_i(req), .we_i(we), .addr_i(addr),
      .din_i(din), .cas_window_i(cas_win), .ack_o(ack[0]), .rdata_o(rdata[0]),
      .mem_req_o(mreq[0]), .mem_we_o(mwe[0]), .mem_addr_o(maddr[0]), .mem_din_o(mdin[0]),
      .mem_dout_i(mem_dout), .mem_ack_i(mack[0] | force_ack), .busy_o(busy[0]),
      .grant_o(grant[0]), .timeout_o(tmo[0]));

   sdram_port_arbiter #(.ADDR_W(AW), .TIMEOUT(4), .STARVE(256)) u_b (
      .clk_sys(clk_sys), .reset_n(reset_n), .req_i(req), .we_i(we), .addr_i(addr),
      .din_i(din), .cas_window_i(cas_win), .ack_o(ack[1]), .rdata_o(rdata[1]),
      .mem_req_o(mreq[1]), .mem_we_o(mwe[1]), .mem_addr_o(maddr[1]), .mem_din_o(mdin[1]),
      .mem_dout_i(mem_dout), .mem_ack_i(mack[1] | force_ack), .busy_o(busy[1]),
      .grant_o(grant[1]), .timeout_o(tmo[1]));

   int n_chk  = 0;
   int n_fail = 0;
   int sel    = 0;
   int lat    = 1;
   int mreq_cnt = 0;
   int rcnt [2];

   typedef struct {
      logic [3:0]    ack;
      logic [7:0]    rdata;
      logic          to;
      logic [AW-1:0] addr;
      logic          we;
      logic [7:0]    din;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      int            slot;
      logic          we;
      logic [AW-1:0] addr;
      logic [7:0]    din;
      logic [7:0]    dout;
      int            lat;
      logic [7:0]    exp_rd;
      logic          exp_to;
      int            exp_lat;
   } vec_t;
   vec_t vec [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Memory model: acks lat cycles after mem_req_o; lat=0 never acks.
   always @(negedge clk_sys) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset_n) begin
            rcnt[i] = 0;
            mack[i] = 1'b0;
         end else if (mreq[i]) begin
            rcnt[i] = lat;
            mack[i] = 1'b0;
         end else if (rcnt[i] > 0) begin
            rcnt[i] = rcnt[i] - 1;
            mack[i] = (rcnt[i] == 0);
         end else begin
            mack[i] = 1'b0;
         end
      end
   end

   always @(negedge clk_sys) begin
      exp_t e;
      if (reset_n) begin
         if (mreq[sel]) begin
            mreq_cnt++;
            if (exp_q.size() != 0) begin
               chk("mem_addr_at_req", 32'(maddr[sel]), 32'(exp_q[0].addr));
               chk("mem_we_at_req", 32'(mwe[sel]), 32'(exp_q[0].we));
               chk("mem_din_at_req", 32'(mdin[sel]), 32'(exp_q[0].din));
            end
         end
         if (ack[sel] != 4'b0000) begin
            if (exp_q.size() == 0) begin
               chk("ack_unexpected", 32'(ack[sel]), 32'h0);
            end else begin
               e = exp_q.pop_front();
               chk("ack_vector", 32'(ack[sel]), 32'(e.ack));
               chk("rdata", 32'(rdata[sel]), 32'(e.rdata));
               chk("timeout_o", 32'(tmo[sel]), 32'(e.to));
               chk("mem_addr_held", 32'(maddr[sel]), 32'(e.addr));
            end
         end
      end
   end

   task automatic wait_ack(input int slot, output int n);
      n = 0;
      do begin
         @(negedge clk_sys);
         n++;
      end while (!ack[sel][slot] && n < 60);
      if (!ack[sel][slot]) chk("ack_wait_expired", 32'(ack[sel]), 32'(4'b0001 << slot));
   endtask

   task automatic do_reset();
      @(posedge clk_sys); #1;
      reset_n = 1'b0; req = 4'b0000; force_ack = 1'b0;
      repeat (2) @(posedge clk_sys);
      #1 reset_n = 1'b1;
   endtask

   task automatic push_exp(input int slot, input logic [7:0] rd, input logic to_f);
      exp_q.push_back('{ack: 4'b0001 << slot, rdata: rd, to: to_f,
                        addr: addr[slot*AW +: AW], we: we[slot], din: din[slot*8 +: 8]});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t v;
      int   n;
      int   base;

      vec[0] = '{2, 1'b0, 23'h001234, 8'h00, 8'h5A, 2, 8'h5A, 1'b0, 5};
      vec[1] = '{0, 1'b1, 23'h7FFFFF, 8'hA5, 8'h33, 1, 8'h5A, 1'b0, 4};
      vec[2] = '{1, 1'b0, 23'h000000, 8'h00, 8'hC3, 3, 8'hC3, 1'b0, 6};
      vec[3] = '{1, 1'b1, 23'h555555, 8'h3C, 8'h11, 0, 8'hC3, 1'b1, 7};
      vec[4] = '{3, 1'b0, 23'h123456, 8'h00, 8'h81, 1, 8'h81, 1'b0, 4};
      vec[5] = '{2, 1'b0, 23'h2AAAAA, 8'h00, 8'h11, 0, 8'hFF, 1'b1, 7};
      vec[6] = '{3, 1'b0, 23'h0F0F0F, 8'h00, 8'h7E, 4, 8'h7E, 1'b0, 7};
      vec[7] = '{0, 1'b0, 23'h3C3C3C, 8'h00, 8'h99, 5, 8'hFF, 1'b1, 7};

      reset_n = 1'b0; req = '0; we = '0; addr = '0; din = '0;
      cas_win = 1'b0; mem_dout = 8'h00; force_ack = 1'b0;
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      chk("rst_ack", 32'(ack[0]), 32'h0);
      chk("rst_rdata", 32'(rdata[0]), 32'h0);
      chk("rst_mem_req", 32'(mreq[0]), 32'h0);
      chk("rst_mem_we", 32'(mwe[0]), 32'h0);
      chk("rst_mem_addr", 32'(maddr[0]), 32'h0);
      chk("rst_mem_din", 32'(mdin[0]), 32'h0);
      chk("rst_busy", 32'(busy[0]), 32'h0);
      chk("rst_grant", 32'(grant[0]), 32'h0);
      chk("rst_timeout", 32'(tmo[0]), 32'h0);
      @(posedge clk_sys); #1 reset_n = 1'b1;

      // Vector table: single requests, reads/writes, timeout boundaries.
      sel = 0; cas_win = 1'b1;
      for (int i = 0; i < 8; i++) begin
         v = vec[i];
         @(posedge clk_sys); #1;
         lat = v.lat; mem_dout = v.dout;
         we[v.slot] = v.we;
         addr[v.slot*AW +: AW] = v.addr;
         din[v.slot*8 +: 8] = v.din;
         exp_q.push_back('{ack: 4'b0001 << v.slot, rdata: v.exp_rd, to: v.exp_to,
                           addr: v.addr, we: v.we, din: v.din});
         req = 4'b0001 << v.slot;
         wait_ack(v.slot, n);
         chk("ack_latency", 32'(n), 32'(v.exp_lat));
         @(posedge clk_sys); #1 req = 4'b0000;
      end
      repeat (3) @(negedge clk_sys);
      chk("table_queue_drained", 32'(exp_q.size()), 32'h0);

      // Contention on the default-threshold instance.
      do_reset();
      sel = 1; cas_win = 1'b0; lat = 1; mem_dout = 8'h42; we = '0; din = '0;
      for (int k = 0; k < 4; k++) addr[k*AW +: AW] = 23'h010000 + 23'(k);
      for (int k = 0; k < 3; k++) push_exp(k, 8'h42, 1'b0);
      @(posedge clk_sys); #1 req = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         wait_ack(k, n);
         @(posedge clk_sys); #1 req[k] = 1'b0;
      end
      repeat (4) begin
         @(negedge clk_sys);
         chk("cas_blocked_busy", 32'(busy[1]), 32'h0);
      end
      @(posedge clk_sys); #1 cas_win = 1'b1;
      push_exp(3, 8'h42, 1'b0);
      wait_ack(3, n);
      chk("cas_window_grant", 32'(grant[1]), 32'h3);
      @(posedge clk_sys); #1 req = 4'b0000; cas_win = 1'b0;
      repeat (3) @(negedge clk_sys);
      chk("contention_queue_drained", 32'(exp_q.size()), 32'h0);

      // Starvation: cassette promoted over a continuous CPU requester.
      do_reset();
      sel = 0; lat = 1; mem_dout = 8'h24;
      push_exp(2, 8'h24, 1'b0);
      push_exp(2, 8'h24, 1'b0);
      push_exp(3, 8'h24, 1'b0);
      req = 4'b1100;
      wait_ack(2, n); chk("starve_cpu1_lat", 32'(n), 32'd4);
      wait_ack(2, n); chk("starve_cpu2_lat", 32'(n), 32'd4);
      wait_ack(3, n); chk("starve_cas_lat", 32'(n), 32'd4);
      chk("starve_grant", 32'(grant[0]), 32'h3);
      @(posedge clk_sys); #1 req = 4'b0000;
      repeat (3) @(negedge clk_sys);
      chk("starve_queue_drained", 32'(exp_q.size()), 32'h0);

      // Reset during WAIT, then a stray mem_ack_i after release.
      do_reset();
      lat = 0; req = 4'b0100;
      repeat (3) @(negedge clk_sys);
      chk("busy_in_wait", 32'(busy[0]), 32'h1);
      @(posedge clk_sys); #1 reset_n = 1'b0; req = 4'b0000;
      @(negedge clk_sys);
      chk("midrst_busy", 32'(busy[0]), 32'h0);
      chk("midrst_mem_addr", 32'(maddr[0]), 32'h0);
      @(posedge clk_sys); @(posedge clk_sys); #1 reset_n = 1'b1; force_ack = 1'b1;
      repeat (3) begin
         @(negedge clk_sys);
         chk("post_rst_ack", 32'(ack[0]), 32'h0);
         chk("post_rst_busy", 32'(busy[0]), 32'h0);
      end
      force_ack = 1'b0;

      // Cancellation: a one-cycle CPU pulse while ioctl is served.
      do_reset();
      lat = 2; mem_dout = 8'h66; we = '0;
      base = mreq_cnt;
      push_exp(0, 8'h66, 1'b0);
      req = 4'b0001;
      @(posedge clk_sys); #1 req[2] = 1'b1;
      @(posedge clk_sys); #1 req[2] = 1'b0;
      wait_ack(0, n);
      @(posedge clk_sys); #1 req = 4'b0000;
      repeat (6) begin
         @(negedge clk_sys);
         chk("cancel_idle", 32'(busy[0]), 32'h0);
      end
      chk("cancel_mem_req_count", 32'(mreq_cnt - base), 32'd1);

      // Request dropped right after grant still completes.
      lat = 1; mem_dout = 8'h5C;
      push_exp(1, 8'h5C, 1'b0);
      @(posedge clk_sys); #1 req = 4'b0010;
      @(posedge clk_sys); #1 req = 4'b0000;
      wait_ack(1, n);
      chk("dropped_after_grant_lat", 32'(n), 32'd3);
      repeat (3) @(negedge clk_sys);
      chk("final_queue_drained", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
